// File: rtl/mio_bus_arbiter_if.sv
// mio_bus_arbiter_if
// Bundles the two master request channels and the shared bus port of the
// memory-mapped I/O arbiter.
//   m0_* / m1_* : req, we, addr, wdata in; ack pulse and rdata out
//   bus_*       : addr, mem_w, wdata out to the decoder; rdata back from it
//   busy, owner : arbiter status
// Modports:
//   master : the requester and bus-decoder side (drives reqs and bus_rdata)
//   slave  : the arbiter side
interface mio_bus_arbiter_if;
   logic        m0_req;
   logic        m0_we;
   logic [31:0] m0_addr;
   logic [31:0] m0_wdata;
   logic        m0_ack;
   logic [31:0] m0_rdata;

   logic        m1_req;
   logic        m1_we;
   logic [31:0] m1_addr;
   logic [31:0] m1_wdata;
   logic        m1_ack;
   logic [31:0] m1_rdata;

   logic [31:0] bus_addr;
   logic        bus_mem_w;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;

   logic        busy;
   logic        owner;

   modport master (
      output m0_req, m0_we, m0_addr, m0_wdata,
      input  m0_ack, m0_rdata,
      output m1_req, m1_we, m1_addr, m1_wdata,
      input  m1_ack, m1_rdata,
      input  bus_addr, bus_mem_w, bus_wdata,
      output bus_rdata,
      input  busy, owner
   );

   modport slave (
      input  m0_req, m0_we, m0_addr, m0_wdata,
      output m0_ack, m0_rdata,
      input  m1_req, m1_we, m1_addr, m1_wdata,
      output m1_ack, m1_rdata,
      output bus_addr, bus_mem_w, bus_wdata,
      input  bus_rdata,
      output busy, owner
   );
endinterface

// File: rtl/mio_bus_arbiter.sv
// mio_bus_arbiter
// Shares the single memory-mapped I/O bus port between the CPU (master 0)
// and a second bus master (master 1). Each transfer runs through issue,
// read-latency wait and acknowledge phases; ties go round-robin.
// Ports:
//   clk   : system clock, all state on the rising edge
//   rst   : synchronous active-high reset
//   mio   : mio_bus_arbiter_if.slave (master channels, bus port, status)
// Parameters:
//   RD_LAT    : cycles from the bus-sampling edge to valid bus_rdata (1..7)
//   IDLE_ADDR : address parked on the bus between transfers (must decode to RAM)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no transfer; arbitrate and latch the winner's request
// ST_ISSUE | request on the bus; bus_mem_w pulses here for writes
// ST_WAIT  | read latency countdown, address held for the decoder
// ST_ACK   | one-cycle ack to the owner; bus parked at IDLE_ADDR
module mio_bus_arbiter #(
   parameter int unsigned RD_LAT    = 2,
   parameter logic [31:0] IDLE_ADDR = 32'h0000_0000
) (
   input logic              clk,
   input logic              rst,
   mio_bus_arbiter_if.slave mio
);

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_ACK} state_t;

   localparam logic [2:0] WAIT_INIT = 3'(RD_LAT - 1);

   state_t      state_q, state_d;
   logic        owner_q, owner_d;
   logic        last_owner_q, last_owner_d;
   logic [2:0]  wait_q, wait_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        mem_w_q, mem_w_d;
   logic        ack0_q, ack0_d;
   logic        ack1_q, ack1_d;
   logic [31:0] rdata0_q, rdata0_d;
   logic [31:0] rdata1_q, rdata1_d;
   logic        grant_m1;
   logic        enter_ack;

   // m1 wins when it is alone, or on a tie when m0 went last.
   assign grant_m1 = mio.m1_req & (~mio.m0_req | ~last_owner_q);

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      wait_d       = wait_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      mem_w_d      = mem_w_q;
      ack0_d       = 1'b0;
      ack1_d       = 1'b0;
      rdata0_d     = rdata0_q;
      rdata1_d     = rdata1_q;
      enter_ack    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (mio.m0_req | mio.m1_req) begin
               owner_d      = grant_m1;
               last_owner_d = grant_m1;
               addr_d       = grant_m1 ? mio.m1_addr  : mio.m0_addr;
               wdata_d      = grant_m1 ? mio.m1_wdata : mio.m0_wdata;
               mem_w_d      = grant_m1 ? mio.m1_we    : mio.m0_we;
               state_d      = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            // mem_w_q still holds the latched direction while in ISSUE.
            mem_w_d = 1'b0;
            if (mem_w_q) begin
               enter_ack = 1'b1;
            end else begin
               wait_d  = WAIT_INIT;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (wait_q != 3'd0) begin
               wait_d = wait_q - 3'd1;
            end else begin
               if (owner_q) rdata1_d = mio.bus_rdata;
               else         rdata0_d = mio.bus_rdata;
               enter_ack = 1'b1;
            end
         end
         ST_ACK: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (enter_ack) begin
         state_d = ST_ACK;
         ack0_d  = ~owner_q;
         ack1_d  = owner_q;
         addr_d  = IDLE_ADDR;
         wdata_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         owner_q      <= 1'b0;
         last_owner_q <= 1'b1;
         wait_q       <= 3'd0;
         addr_q       <= IDLE_ADDR;
         wdata_q      <= '0;
         mem_w_q      <= 1'b0;
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         wait_q       <= wait_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         mem_w_q      <= mem_w_d;
         ack0_q       <= ack0_d;
         ack1_q       <= ack1_d;
         rdata0_q     <= rdata0_d;
         rdata1_q     <= rdata1_d;
      end
   end

   assign mio.bus_addr  = addr_q;
   assign mio.bus_wdata = wdata_q;
   assign mio.bus_mem_w = mem_w_q;
   assign mio.m0_ack    = ack0_q;
   assign mio.m1_ack    = ack1_q;
   assign mio.m0_rdata  = rdata0_q;
   assign mio.m1_rdata  = rdata1_q;
   assign mio.owner     = owner_q;
   assign mio.busy      = (state_q != ST_IDLE);

endmodule

// File: doc/mio_bus_arbiter.md
# mio_bus_arbiter

Two-master arbiter for the memory-mapped I/O bus. It shares the single bus port (address, write strobe, write data, read data) between the CPU (master 0) and a second bus master such as a DMA or graphics-fill engine (master 1). It sits between both masters and the bus decoder. Each transfer is sequenced through issue, read-latency wait and acknowledge phases. Ties are resolved round-robin, so neither master starves.

## Interface
Parameters:
- RD_LAT, 2, cycles from the bus-sampling edge until bus_rdata is valid; legal range 1..7.
- IDLE_ADDR, 32'h0000_0000, address driven when no transfer is active; must decode to RAM (region 0x0), never to region 0xB, whose writes ignore mem_w.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- m0_req  in  1  CPU transfer request, held until m0_ack
- m0_we  in  1  CPU write (1) / read (0)
- m0_addr  in  32  CPU byte address
- m0_wdata  in  32  CPU write data
- m0_ack  out  1  one-cycle completion pulse to CPU
- m0_rdata  out  32  CPU read data, valid while m0_ack=1, held afterwards
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata: same as m0_* for master 1
- bus_addr  out  32  to bus addr_bus
- bus_mem_w  out  1  to bus mem_w
- bus_wdata  out  32  to bus Cpu_data2bus
- bus_rdata  in  32  from bus Cpu_data4bus
- busy  out  1  high in every state except IDLE
- owner  out  1  master currently granted; meaningful while busy=1

## Operation
- States: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - Neither req high: stay in IDLE.
  - Exactly one req high: grant that master.
  - Both high: grant the master that is not last_owner.
  - On grant: register bus_addr, bus_wdata, bus_mem_w=we and owner from the granted master, update last_owner, then go to ISSUE. Master inputs are sampled only at the grant edge.
- ISSUE: bus outputs stable. bus_mem_w is high only in this state, and only for writes. Writes go to ACK; reads load wait_cnt=RD_LAT-1 and go to WAIT.
- WAIT:
  - bus_addr held and bus_mem_w=0; the decoder re-samples every clock, so the address must stay put.
  - wait_cnt>0: decrement.
  - wait_cnt==0: capture bus_rdata into the owner's rdata register, then go to ACK.
- ACK: owner's ack=1 for exactly one cycle. bus_addr=IDLE_ADDR, bus_mem_w=0, bus_wdata=0. Next state is always IDLE. Req lines are ignored in ACK, even if still high.
- The non-owner's ack and rdata never change during the owner's transfer.
- Writes leave the owner's rdata unchanged.
- Reset, in any state including mid-transfer:
  - Next state IDLE; aborted transfers produce no ack.
  - All outputs zero except bus_addr=IDLE_ADDR.
  - last_owner=1, so master 0 wins the first tie.
  - wait_cnt=0.

## Timing
- Request seen high in cycle t (IDLE) -> ISSUE in t+1.
- Write: bus_mem_w=1 in t+1 only; ack in t+2. Throughput: 3 cycles per write.
- Read: WAIT for RD_LAT cycles (t+2 .. t+1+RD_LAT); bus_rdata sampled at the end of t+1+RD_LAT; ack and rdata valid in t+2+RD_LAT.
- Back-to-back: a req held through ACK is re-evaluated in IDLE the following cycle. Minimum gap between grants is 1 IDLE cycle.
- Contention: both reqs held continuously gives grants alternating m0, m1, m0, ... Worst-case wait for either master is one foreign transfer plus 1 cycle.
- No combinational path from any input to any output; all outputs are registered.

## Test plan
- Reset: assert rst for 2 cycles mid-stream -> bus_addr=0x00000000, bus_mem_w=0, both acks=0, both rdata=0, busy=0, owner=0.
- m0 write, addr 0xF0000000, data 0x12345678, req at t:
  - bus_mem_w=1 with bus_wdata=0x12345678 in t+1 only.
  - m0_ack=1 in t+2; m1_ack=0 throughout.
- m1 read, addr 0x00000010, RD_LAT=2; bench drives bus_rdata=0xDEADBEEF from t+2:
  - bus_addr=0x00000010 in t+1..t+3, bus_mem_w=0.
  - m1_rdata=0xDEADBEEF and m1_ack=1 in t+4.
  - m0_rdata unchanged.
- Contention: after reset, m0 and m1 reads requested together and held -> grant order m0, m1, m0, m1; each ack lands on the correct master with the correct data.
- Abort: rst pulsed during WAIT of an m0 read -> next cycle IDLE, bus_addr=IDLE_ADDR, no m0_ack ever issued for that transfer.
- m0 write with m0_req held high through ACK -> no new grant in the ACK cycle; IDLE follows, then a second grant and ISSUE one cycle later (second write at t+4).
